// File: rtl/fmadd_seq_ctrl_if.sv
// Request/result handshake bundle for the fused multiply-add sequencer.
//   in_valid/in_ready   : request handshake (in_op, in_rm, in_tag payload)
//   out_valid/out_ready : result handshake (out_tag, out_err payload)
// master = requester/consumer side, slave = sequencer side.
interface fmadd_seq_ctrl_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_tag, out_err
    );
endinterface

// File: rtl/fmadd_seq_ctrl.sv
// Sequencer for a multi-stage fused multiply-add datapath.
// Walks one request at a time through MUL (MUL_LAT cycles), PN, ADD
// (skipped for FMUL) and RND, then presents the result in DONE until the
// consumer takes it. Illegal ops go straight to DONE with out_err set.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : abort whatever is in flight (next state IDLE)
//   bus (slave)       : request/result handshake, see fmadd_seq_ctrl_if
//   mul_en..rnd_en    : one-hot datapath stage enables
//   op_q, rm_q        : op and rounding mode of the in-flight request
//   busy              : sequencer not idle
//   op_count          : number of completed result transfers (wraps)
module fmadd_seq_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    fmadd_seq_ctrl_if.slave bus,
    output logic        mul_en,
    output logic        pn_en,
    output logic        add_en,
    output logic        rnd_en,
    output logic [2:0]  op_q,
    output logic [2:0]  rm_q,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_PN   = 3'd2,
        S_ADD  = 3'd3,
        S_RND  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [2:0] OP_FMUL  = 3'b000;
    localparam logic [2:0] OP_MAX   = 3'b100;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_d, rm_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             in_rdy;
    logic             accept;
    logic             xfer;
    logic             in_legal;
    state_t           start_state;

    always_comb begin
        // Reset also gates in_ready so nothing is accepted while rst is high.
        in_rdy      = !rst && !flush &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_DONE) && bus.out_ready));
        accept      = bus.in_valid && in_rdy;
        xfer        = (state_q == S_DONE) && bus.out_ready && !flush && !rst;
        in_legal    = (bus.in_op <= OP_MAX);
        start_state = in_legal ? S_MUL : S_DONE;

        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rm_d       = rm_q;
        tag_d      = tag_q;
        err_d      = err_q;
        op_count_d = op_count_q;

        case (state_q)
            S_IDLE: if (accept) state_d = start_state;
            S_MUL: begin
                if (cnt_q == 4'd0) state_d = S_PN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_PN:   state_d = (op_q == OP_FMUL) ? S_RND : S_ADD;
            S_ADD:  state_d = S_RND;
            S_RND:  state_d = S_DONE;
            S_DONE: begin
                // Back-to-back: a request taken while the result leaves
                // starts immediately without passing through IDLE.
                if (bus.out_ready) state_d = accept ? start_state : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d  = bus.in_op;
            rm_d  = bus.in_rm;
            tag_d = bus.in_tag;
            err_d = !in_legal;
            cnt_d = MUL_LOAD;
        end

        if (flush) state_d = S_IDLE;

        if (xfer) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 3'b000;
            rm_q       <= 3'b000;
            tag_q      <= '0;
            err_q      <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    // Stage enables decode straight from state; forced low while in reset.
    assign mul_en        = !rst && (state_q == S_MUL);
    assign pn_en         = !rst && (state_q == S_PN);
    assign add_en        = !rst && (state_q == S_ADD);
    assign rnd_en        = !rst && (state_q == S_RND);
    assign busy          = !rst && (state_q != S_IDLE);
    assign bus.out_valid = !rst && (state_q == S_DONE);
    assign bus.in_ready  = in_rdy;
    assign bus.out_tag   = tag_q;
    assign bus.out_err   = err_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_fmadd_seq_ctrl.sv
module tb_fmadd_seq_ctrl;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        mul_en, pn_en, add_en, rnd_en, busy;
    logic [2:0]  op_q, rm_q;
    logic [15:0] op_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;

    fmadd_seq_ctrl_if #(.TAG_W(4)) bus ();

    fmadd_seq_ctrl #(.MUL_LAT(L), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .mul_en(mul_en), .pn_en(pn_en), .add_en(add_en), .rnd_en(rnd_en),
        .op_q(op_q), .rm_q(rm_q), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stage, one-hot {rnd,add,pn,mul}, t cycles after acceptance.
    function automatic logic [3:0] exp_stage(input logic [2:0] op, input int t);
        int rnd_t;
        if (op > 3'd4) return 4'b0000;
        rnd_t = (op == 3'd0) ? L + 2 : L + 3;
        if (t >= 1 && t <= L)          return 4'b0001;
        if (t == L + 1)                return 4'b0010;
        if (op != 3'd0 && t == L + 2)  return 4'b0100;
        if (t == rnd_t)                return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] en_vec();
        return 32'({rnd_en, add_en, pn_en, mul_en});
    endfunction

    // One request from acceptance to result transfer. 'pre' means it was
    // already accepted in the previous DONE cycle; 'chain' offers the next
    // request in this one's final DONE cycle.
    task automatic do_op(input logic [2:0] op, input logic [2:0] rm, input logic [3:0] tag,
                         input int stall, input bit pre, input bit chain,
                         input logic [2:0] nop, input logic [2:0] nrm, input logic [3:0] ntag);
        bit legal;
        int lat;
        legal = (op <= 3'd4);
        lat   = !legal ? 1 : ((op == 3'd0) ? L + 3 : L + 4);
        if (!pre) begin
            bus.in_valid = 1'b1; bus.in_op = op; bus.in_rm = rm; bus.in_tag = tag;
            bus.out_ready = 1'b0;
            #1 check("acc_ready", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (int t = 1; t < lat; t++) begin
            #1;
            check("stage_en", en_vec(), 32'(exp_stage(op, t)));
            check("no_valid", 32'(bus.out_valid), 32'd0);
            check("op_held", 32'({op_q, rm_q}), 32'({op, rm}));
            @(posedge clk); #1;
        end
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            #1;
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_tag", 32'({bus.out_err, bus.out_tag}), 32'({~legal, tag}));
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.in_valid = 1'b1; bus.in_op = nop; bus.in_rm = nrm; bus.in_tag = ntag;
        end
        #1;
        check("done_valid", 32'(bus.out_valid), 32'd1);
        check("done_tag", 32'({bus.out_err, bus.out_tag}), 32'({~legal, tag}));
        check("done_en", en_vec(), 32'd0);
        if (chain) check("chain_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check("op_count", 32'(op_count), 32'(exp_cnt));
        if (!chain) check("idle_after", 32'(busy), 32'd0);
        else check("chain_mul", 32'(mul_en | (op == op && nop > 3'd4 ? bus.out_valid : 1'b0)), 32'd1);
    endtask

    initial begin
        logic [2:0] op, rm, nop, nrm;
        logic [3:0] tag, ntag;
        bit         pre, chain;

        bus.in_valid = 1'b1; bus.in_op = 3'b001; bus.in_rm = 3'b010; bus.in_tag = 4'h7;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_en", en_vec(), 32'd0);
        check("rst_regs", 32'({op_q, rm_q, bus.out_tag, bus.out_err}), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;

        // Scenario 1/2/3/5
        do_op(3'b001, 3'b011, 4'd5, 0, 1'b0, 1'b0, 3'b0, 3'b0, 4'd0);
        do_op(3'b000, 3'b001, 4'd3, 0, 1'b0, 1'b0, 3'b0, 3'b0, 4'd0);
        do_op(3'b010, 3'b100, 4'd8, 3, 1'b0, 1'b1, 3'b011, 3'b010, 4'd11);
        do_op(3'b011, 3'b010, 4'd11, 0, 1'b1, 1'b0, 3'b0, 3'b0, 4'd0);
        do_op(3'b110, 3'b000, 4'd2, 1, 1'b0, 1'b0, 3'b0, 3'b0, 4'd0);
        do_op(3'b100, 3'b111, 4'd1, 0, 1'b0, 1'b0, 3'b0, 3'b0, 4'd0);

        // Scenario 4: flush in PN, then flush racing a request in IDLE
        bus.in_valid = 1'b1; bus.in_op = 3'b001; bus.in_rm = 3'b0; bus.in_tag = 4'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (L) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_in_pn", 32'(pn_en), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush_idle", 32'(busy), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_cnt", 32'(op_count), 32'(exp_cnt));
        bus.in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_block", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_noacc", 32'(busy), 32'd0);

        // Randomised sequence against the reference model
        pre = 1'b0;
        op = 3'($urandom_range(0, 7)); rm = 3'($urandom); tag = 4'($urandom);
        for (int i = 0; i < 24; i++) begin
            nop = 3'($urandom_range(0, 7)); nrm = 3'($urandom); ntag = 4'($urandom);
            chain = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_op(op, rm, tag, int'($urandom_range(0, 2)), pre, chain, nop, nrm, ntag);
            pre = chain; op = nop; rm = nrm; tag = ntag;
        end

        // Scenario 6: reset in ADD
        bus.in_valid = 1'b1; bus.in_op = 3'b001; bus.in_rm = 3'b101; bus.in_tag = 4'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (L + 1) @(posedge clk);
        #1;
        check("pre_rst_add", 32'(add_en), 32'd1);
        rst = 1'b1; flush = 1'b1; bus.in_valid = 1'b1;
        #1;
        check("rst_mid_en", en_vec(), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        exp_cnt = 16'd0;
        check("rst_mid_regs", 32'({op_q, rm_q, bus.out_tag, bus.out_err}), 32'd0);
        check("rst_mid_cnt", 32'(op_count), 32'd0);
        check("rst_mid_idle", 32'(busy | bus.out_valid), 32'd0);

        // Wrap: stream illegal ops, one completion per cycle
        bus.in_valid = 1'b1; bus.in_op = 3'b111; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_ffff", 32'(op_count), 32'hFFFF);
        check("stream_err", 32'({bus.out_valid, bus.out_err}), 32'b11);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("cnt_wrap", 32'(op_count), 32'h0);
        check("wrap_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fmadd_seq_ctrl.md
FMADD_SEQ_CTRL -- requirements
Module: fmadd_seq_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2: multiplier latency in cycles; legal range 1..15.
REQ-002 Parameter TAG_W, default 4: width of the request tag.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: request present.
REQ-006 Port in_ready, output, 1: request accepted this cycle when in_valid=1.
REQ-007 Port in_op, input, 3: 000 FMUL, 001 FMADD, 010 FMSUB, 011 FNMADD, 100 FNMSUB; 101-111 illegal.
REQ-008 Port in_rm, input, 3: rounding mode, passed through unchanged.
REQ-009 Port in_tag, input, TAG_W: request identifier.
REQ-010 Port flush, input, 1: abort the in-flight operation.
REQ-011 Port mul_en, output, 1: multiplier stage enable.
REQ-012 Port pn_en, output, 1: multiply post-normalization stage enable.
REQ-013 Port add_en, output, 1: addend alignment/add stage enable.
REQ-014 Port rnd_en, output, 1: rounding stage enable.
REQ-015 Port op_q, output, 3; rm_q, output, 3: registered op and rm of the in-flight request.
REQ-016 Port out_valid, output, 1; out_ready, input, 1: result handshake.
REQ-017 Port out_tag, output, TAG_W; out_err, output, 1: tag of the completed request; illegal-op flag.
REQ-018 Port busy, output, 1: state is not IDLE.
REQ-019 Port op_count, output, 16: completed-transfer counter.

Function
REQ-020 States: IDLE, MUL, PN, ADD, RND, DONE; one-hot or binary encoding is free, but it shall never enter an unreachable state.
REQ-021 Acceptance (in_valid & in_ready & !flush) captures in_op, in_rm, in_tag into op_q, rm_q, out_tag.
REQ-022 A legal op enters MUL; an illegal op enters DONE directly with out_err=1.
REQ-023 MUL lasts exactly MUL_LAT cycles, counted by a 4-bit down-counter loaded with MUL_LAT-1 on entry; then PN.
REQ-024 PN lasts 1 cycle; then ADD for ops 001-100, or RND for FMUL (ADD skipped).
REQ-025 ADD lasts 1 cycle, then RND; RND lasts 1 cycle, then DONE.
REQ-026 Enables are combinational from state: mul_en=MUL, pn_en=PN, add_en=ADD, rnd_en=RND; at most one is high in any cycle.
REQ-027 out_valid=1 only in DONE; it, out_tag and out_err hold stable until out_ready=1.
REQ-028 In DONE with out_ready=1, the next state is IDLE, or MUL/DONE when a new request is accepted in the same cycle.
REQ-029 in_ready = !flush & (IDLE | (DONE & out_ready)); back-to-back operation has no bubble.
REQ-030 Latency from acceptance edge to out_valid: MUL_LAT+4 cycles for FMADD-class ops, MUL_LAT+3 for FMUL, 1 for illegal ops.
REQ-031 flush in any state forces IDLE on the next edge, with no out_valid pulse and no op_count increment; flush dominates in_valid and out_ready in the same cycle.
REQ-032 op_count increments by 1 on each out_valid & out_ready & !flush; it wraps from 0xFFFF to 0x0000, and illegal-op completions are counted.
REQ-033 out_err clears on the next acceptance of a legal op.
REQ-034 op_q and rm_q are held constant from acceptance through completion.

Reset
REQ-035 rst=1 on an edge sets state=IDLE, counter=0, op_q=000, rm_q=000, out_tag=0, out_err=0, op_count=0.
REQ-036 During reset cycles all enables, out_valid and busy are 0, and in_ready=0.
REQ-037 Reset dominates flush and in_valid; mid-operation reset discards the request with no output.

Verification
REQ-038 Scenario 1: MUL_LAT=2, FMADD tag=5 accepted at cycle 0, out_ready=1 -> mul_en in cycles 1-2, pn_en 3, add_en 4, rnd_en 5, out_valid with tag 5 in 6, op_count=1.
REQ-039 Scenario 2: FMUL tag=3 -> add_en never asserts; out_valid in cycle 5.
REQ-040 Scenario 3: out_ready=0 for 3 cycles in DONE -> out_valid and tag held; a second request is accepted the cycle out_ready rises and its mul_en starts the next cycle.
REQ-041 Scenario 4: flush in PN -> IDLE next cycle, no out_valid, op_count unchanged; flush with in_valid in IDLE -> not accepted.
REQ-042 Scenario 5: in_op=110 -> out_valid 1 cycle later with out_err=1, no stage enable asserted.
REQ-043 Scenario 6: rst asserted in ADD -> all outputs at reset values; preload op_count=0xFFFF by 65535 transfers, then one more -> 0x0000.
